axi4lite_sram_slave: RTL
========================

# axi4lite_sram_slave

AXI4-Lite slave memory sitting directly downstream of the mriscvcore master port; it consumes the core's AW/W/AR transactions and returns B and R responses, serving as unified instruction/data RAM in simulation and FPGA builds. It holds a word-organised array with byte-lane write enables. Independent write and read FSMs can run concurrently. A programmable number of read wait-states lets the bench exercise the core's Rvalid back-pressure.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 32-bit words; default is 4 KiB.
- `READ_WAIT`, default 0: extra idle cycles between AR handshake and Rvalid; range 0..15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `AWdata` input 32: write byte address.
- `AWvalid` input 1 / `AWready` output 1: write-address handshake.
- `AWprot` input 3: accepted, ignored.
- `Wdata` input 32 / `Wstrb` input 4: write data and byte enables; bit i enables byte i.
- `Wvalid` input 1 / `Wready` output 1: write-data handshake.
- `Bvalid` output 1 / `Bready` input 1: write-response handshake.
- `ARdata` input 32: read byte address.
- `ARvalid` input 1 / `ARready` output 1: read-address handshake.
- `ARprot` input 3: accepted, ignored.
- `Rdata` output 32 / `Rvalid` output 1 / `RReady` input 1: read-data channel.
- `err` output 1: sticky; set on any out-of-range access; cleared only by reset.

## Operation
- **Address decode**
  - Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored.
  - Out of range means any of addr[31:DEPTH_LOG2+2] is nonzero.
- **Write FSM**: states `W_IDLE`, `W_COMMIT`, `W_RESP`.
  - `W_IDLE`:
    - AWready = !aw_got; Wready = !w_got.
    - Each channel is latched independently on its handshake, in any order or in the same cycle.
    - When both are held, or complete on this edge, go to `W_COMMIT`.
  - `W_COMMIT`, one cycle:
    - Write lanes with Wstrb=1; Wstrb=0000 writes nothing.
    - Out-of-range: no write, set err.
    - Then go to `W_RESP`.
  - `W_RESP`:
    - Bvalid=1 until Bready is sampled high.
    - Then go to `W_IDLE` and clear aw_got/w_got.
- **Read FSM**: states `R_IDLE`, `R_WAIT`, `R_DATA`.
  - `R_IDLE`: ARready=1; on handshake, latch the address.
    - Go to `R_WAIT` if READ_WAIT>0, else `R_DATA`.
  - `R_WAIT`: counter runs from READ_WAIT-1 down to 0, then go to `R_DATA`.
  - Rdata is loaded on the edge entering `R_DATA`.
    - Out-of-range returns 32'h0000_0000 and sets err.
  - `R_DATA`: Rvalid=1; Rdata held stable until RReady is sampled high, then go to `R_IDLE`.
- **Same-word collision**: the read sample and the W_COMMIT write occur on the same edge, so Rdata returns the old word (read-before-write).
- Only one outstanding transaction per channel; ready stays low while busy.

## Timing
- **Reset values**: AWready=0, Wready=0, Bvalid=0, ARready=0, Rvalid=0, Rdata=0, err=0.
  - Ready signals rise in the first cycle after rst deasserts.
  - Array contents are not reset.
- **Write latency**: AW and W handshake on edge 0; commit on edge 1; Bvalid high after edge 1.
  - Minimum 2 cycles from the last handshake to Bvalid.
  - AWready/Wready return high the cycle after the B handshake.
- **Read latency**: AR handshake on edge 0; Rvalid high after edge READ_WAIT.
  - With READ_WAIT=0, Rvalid is high in the next cycle.
- **Back-to-back transactions**: one dead cycle minimum between transactions per channel.
- **Reset mid-transaction**: all FSMs return to idle immediately.
  - A pending write is abandoned before commit if still in `W_IDLE`.
  - A write already past `W_COMMIT` stays written.

## Structure
- Shared package `axi4lite_sram_pkg`: write/read state enums, `WAIT_W=4` counter width, and the out-of-range read value constant.
- Sub-module `axi4lite_sram_array`: synchronous 32-bit word array with 4 byte-lane write enables and a registered read port.
  - Read-before-write on the same address.
  - Infers block RAM.
- Top level contains both FSMs, the address latches, decode, and err.

## Test plan
- **Basic write then read**: AW=0x10 and W=0xA5A5_1234 with Wstrb=1111 in the same cycle, Bready=1.
  - Bvalid rises 2 cycles later.
  - Then AR=0x10 with READ_WAIT=0 → Rvalid the next cycle, Rdata=0xA5A5_1234.
- **Byte lanes**: write 0xFFFF_FFFF with strb=1111, then 0x0000_0000 with strb=0101.
  - Read returns 0xFF00_FF00.
- **Split ordering**: W first, AW three cycles later.
  - Wready low after the W handshake.
  - Commit happens only after AW; Bvalid 2 cycles after the AW handshake.
- **Back-pressure**: READ_WAIT=3 and RReady held low for 5 cycles.
  - Rvalid appears 4 cycles after AR and Rdata stays stable.
  - ARready stays low until the cycle after RReady is high.
- **Collision and out-of-range**: read sample of word 4 coincides with W_COMMIT of 0x1 to word 4 (old value 0x0).
  - Rdata=0x0; a later read gives 0x1.
  - AR=0x8000_0000 → Rdata=0 and err=1, sticky.
- **Reset mid-transaction**: assert rst while in `W_RESP`.
  - All outputs go 0 immediately; after release the ready signals are 1.
  - The committed word persists.

Source files
------------

// File: rtl/axi4lite_sram_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM slave: FSM state encodings,
// read wait-state counter width and the data returned for out-of-range reads.
package axi4lite_sram_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_t;

  localparam int WAIT_W = 4;

  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/axi4lite_sram_array.sv
// Synchronous 32-bit word array with per-byte write enables and a registered,
// read-before-write read port; written so that tools map it onto block RAM.
module axi4lite_sram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Non-blocking read and write on the same edge give the old word on a collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (rd_en) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave memory: independent write and read FSMs in front of a word
// array, with optional read wait-states and a sticky out-of-range error flag.
module axi4lite_sram_slave #(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_WAIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AWdata,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [2:0]  AWprot,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  input  logic        Wvalid,
  output logic        Wready,
  output logic        Bvalid,
  input  logic        Bready,
  input  logic [31:0] ARdata,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [2:0]  ARprot,
  output logic [31:0] Rdata,
  output logic        Rvalid,
  input  logic        RReady,
  output logic        err
);

  import axi4lite_sram_pkg::*;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  aw_got, w_got, aw_hs, w_hs, ar_hs;
  logic [DEPTH_LOG2-1:0] aw_idx, ar_idx, ram_raddr;
  logic                  aw_oor, ar_oor, rd_oor, r_oor;
  logic [31:0]           w_data, ram_q;
  logic [3:0]            w_strb, ram_we;
  logic                  ram_re;
  logic [WAIT_W-1:0]     wait_cnt;

  logic [DEPTH_LOG2-1:0] ar_idx_in;
  logic                  ar_oor_in;
  logic                  unused_ok;

  assign ar_idx_in = ARdata[DEPTH_LOG2+1:2];
  assign ar_oor_in = |ARdata[31:DEPTH_LOG2+2];
  assign unused_ok = ^{AWprot, ARprot, AWdata[1:0], ARdata[1:0]};

  // Readies are held low while rst is high so the reset values are all zero.
  assign AWready = (w_state == W_IDLE) && !aw_got && !rst;
  assign Wready  = (w_state == W_IDLE) && !w_got && !rst;
  assign ARready = (r_state == R_IDLE) && !rst;
  assign aw_hs   = AWvalid && AWready;
  assign w_hs    = Wvalid && Wready;
  assign ar_hs   = ARvalid && ARready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    Bvalid = 1'b0;
    ram_we = 4'b0000;
    case (w_state)
      W_IDLE:   if ((aw_got || aw_hs) && (w_got || w_hs)) w_next = W_COMMIT;
      W_COMMIT: begin
        ram_we = aw_oor ? 4'b0000 : w_strb;
        w_next = W_RESP;
      end
      W_RESP: begin
        Bvalid = 1'b1;
        if (Bready) w_next = W_IDLE;
      end
      default:  w_next = W_IDLE;
    endcase
  end

  // The read sample edge is the one entering R_DATA; in R_IDLE the address comes straight off AR.
  always_comb begin
    r_next    = r_state;
    Rvalid    = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = ar_idx;
    rd_oor    = ar_oor;
    case (r_state)
      R_IDLE: begin
        ram_raddr = ar_idx_in;
        rd_oor    = ar_oor_in;
        if (ar_hs) begin
          if (READ_WAIT > 0) begin
            r_next = R_WAIT;
          end else begin
            r_next = R_DATA;
            ram_re = 1'b1;
          end
        end
      end
      R_WAIT: begin
        if (wait_cnt == '0) begin
          r_next = R_DATA;
          ram_re = 1'b1;
        end
      end
      R_DATA: begin
        Rvalid = 1'b1;
        if (RReady) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_idx <= '0;
      aw_oor <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_idx <= AWdata[DEPTH_LOG2+1:2];
        aw_oor <= |AWdata[31:DEPTH_LOG2+2];
      end
      if (w_hs) begin
        w_got  <= 1'b1;
        w_data <= Wdata;
        w_strb <= Wstrb;
      end
      if (w_state == W_RESP && Bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_idx   <= '0;
      ar_oor   <= 1'b0;
      wait_cnt <= '0;
      r_oor    <= 1'b0;
    end else begin
      if (ar_hs) begin
        ar_idx   <= ar_idx_in;
        ar_oor   <= ar_oor_in;
        wait_cnt <= WAIT_W'(READ_WAIT - 1);
      end else if (r_state == R_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (ram_re) r_oor <= rd_oor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if ((w_state == W_COMMIT && aw_oor) || (ram_re && rd_oor)) err <= 1'b1;
  end

  // Outside R_DATA, and for out-of-range reads, Rdata shows the constant rather than stale RAM output.
  assign Rdata = (r_state == R_DATA && !r_oor) ? ram_q : OOR_RDATA;

  axi4lite_sram_array #(.ADDR_W(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (aw_idx),
    .wdata (w_data),
    .rd_en (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

endmodule
